jtag_tap_core: RTL and testbench
================================

// Module: jtag_tap_core
// PURPOSE
//  Parametrised JTAG TAP: 16-state IEEE 1149.1 FSM with built-in instruction register,
//  BYPASS and IDCODE data registers, a TDO mux and N_USER user-DR channels.
//  Sits between the debug pins (TCK/TMS/TDI/TDO) and the debug/scan logic; user channels
//  drive external DR chains (debug module, scan) through select/strobe outputs.
// PARAMETERS
//  IR_WIDTH   5              instruction register width (>=2)
//  IDCODE_VAL 32'h1000_0001  value captured by IDCODE DR (bit0 must be 1)
//  IDCODE_INS 5'b00001       IDCODE opcode; also loaded into IR on reset/TLR
//  N_USER     2              number of user DR channels (1..8)
//  USER_BASE  5'b10000       opcode of user channel 0; channel i = USER_BASE+i
// PORTS
//  TCK           in   1         test clock; all state on posedge
//  TRST          in   1         async reset, active-high; forces Test-Logic-Reset
//  TMS           in   1         test mode select, sampled posedge TCK
//  TDI           in   1         serial data in
//  TDO           out  1         serial data out (combinational mux, see BEHAVIOUR)
//  TDO_en        out  1         1 while in Shift_DR or Shift_IR
//  ir_q          out  IR_WIDTH  current (updated) instruction
//  Reset         out  1         FSM in Test-Logic-Reset
//  Run_idle      out  1         FSM in Run-Test/Idle
//  Capture_DR/Shift_DR/Update_DR  out 1 each  FSM in that DR state
//  Capture_IR/Shift_IR/Update_IR  out 1 each  FSM in that IR state
//  user_sel      out  N_USER    one-hot: ir_q selects user channel i
//  user_tdo      in   N_USER    serial out of each external user chain
// BEHAVIOUR
//  - FSM: 16 states, 4-bit binary-encoded state reg, standard 1149.1 transitions on TMS.
//    TRST=1 -> TLR asynchronously. TMS=1 for 5 TCK from any state -> TLR (inherent).
//  - All state outputs are Moore decodes of the state reg: asserted for exactly the
//    TCK cycles the FSM occupies that state. Reset values: Reset=1, all others 0.
//  - IR: shift reg ir_sr and update reg ir_q. TRST or entry to TLR: ir_q<=IDCODE_INS.
//    Capture_IR: ir_sr <= {(IR_WIDTH-2)'b0,2'b01}. Shift_IR: ir_sr <= {TDI,ir_sr[W-1:1]}
//    (LSB out first). Update_IR: ir_q <= ir_sr on the posedge leaving Update_IR.
//    ir_q unchanged by Capture/Shift; new ir_q visible the cycle after Update_IR.
//  - Decode of ir_q: IDCODE_INS -> IDCODE; USER_BASE..USER_BASE+N_USER-1 -> user i;
//    all-ones and every other code -> BYPASS.
//  - BYPASS: 1-bit reg; Capture_DR loads 0; Shift_DR loads TDI.
//  - IDCODE: 32-bit reg; Capture_DR loads IDCODE_VAL; Shift_DR shifts right, TDI into
//    bit31. Not loaded in other states.
//  - user_sel[i]=1 when ir_q decodes to user i (held outside DR scan too); BYPASS/IDCODE
//    regs not touched while a user channel is selected.
//  - TDO mux: Shift_IR -> ir_sr[0]; Shift_DR -> selected DR bit0 (bypass, idcode[0],
//    user_tdo[i]); otherwise 0. TDO_en=Shift_DR|Shift_IR. No negedge retiming here.
//  - Pause/Exit states hold all shift regs. TRST mid-shift: shift regs keep value
//    (don't-care), ir_q->IDCODE_INS, FSM->TLR immediately.
// STRUCTURE
//  - Package jtag_pkg: TAP state localparams (TLR,RTI,SEL_DR..UPD_IR, 4-bit), DR-select
//    enum (DR_BYPASS, DR_IDCODE, DR_USER), default opcodes.
//  - Sub-module jtag_tap_fsm: state reg + next-state logic + Moore decodes; top holds
//    IR, BYPASS, IDCODE, decode and TDO mux.
// TESTING
//  1 TRST=1 then TMS=1 x5 -> Reset=1, ir_q=5'b00001; TMS=0 -> Run_idle=1 next cycle.
//  2 From RTI, TMS 1,0,0 then shift 32 bits TMS=0 -> TDO stream = 32'h1000_0001 LSB-first.
//  3 Shift IR 5'b11111 and update; shift DR pattern 1,0,1,1 -> TDO = 0,1,0,1 (1-bit delay).
//  4 Capture_IR then shift 5 bits -> TDO = 1,0,0,0,0; load 5'b10001 -> user_sel=2'b10,
//    TDO follows user_tdo[1] during Shift_DR.
//  5 Walk every state via TMS sequences; check exactly one state output high per cycle
//    and Exit1->Pause->Exit2->Shift holds IDCODE shift reg.
//  6 Assert TRST mid Shift_DR -> Reset=1 same cycle, TDO_en=0, ir_q=IDCODE_INS.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared definitions for the JTAG TAP slice.
// Contents: the 16 IEEE 1149.1 TAP states with their 4-bit binary codes, the
// data-register select enum, and the default opcodes and IDCODE value.
package jtag_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'h0,
        RTI    = 4'h1,
        SEL_DR = 4'h2,
        CAP_DR = 4'h3,
        SH_DR  = 4'h4,
        EX1_DR = 4'h5,
        PAU_DR = 4'h6,
        EX2_DR = 4'h7,
        UPD_DR = 4'h8,
        SEL_IR = 4'h9,
        CAP_IR = 4'hA,
        SH_IR  = 4'hB,
        EX1_IR = 4'hC,
        PAU_IR = 4'hD,
        EX2_IR = 4'hE,
        UPD_IR = 4'hF
    } tap_state_t;

    typedef enum logic [1:0] {
        DR_BYPASS = 2'd0,
        DR_IDCODE = 2'd1,
        DR_USER   = 2'd2
    } dr_sel_t;

    localparam int          DEFAULT_IR_WIDTH   = 5;
    localparam logic [31:0] DEFAULT_IDCODE_VAL = 32'h1000_0001;
    localparam logic [4:0]  DEFAULT_IDCODE_INS = 5'b00001;
    localparam logic [4:0]  DEFAULT_USER_BASE  = 5'b10000;
    localparam int          DEFAULT_N_USER     = 2;

endpackage

// File: rtl/jtag_tap_fsm.sv
// TAP controller state machine.
// Ports:
//   tck        test clock, state advances on posedge
//   trst       async active-high reset, forces Test-Logic-Reset
//   tms        test mode select
//   next_tlr   next state is Test-Logic-Reset (lets the IR reload on entry)
//   tlr, rti, cap_dr, sh_dr, upd_dr, cap_ir, sh_ir, upd_ir
//              Moore decodes of the current state
module jtag_tap_fsm
    import jtag_pkg::*;
(
    input  logic tck,
    input  logic trst,
    input  logic tms,
    output logic next_tlr,
    output logic tlr,
    output logic rti,
    output logic cap_dr,
    output logic sh_dr,
    output logic upd_dr,
    output logic cap_ir,
    output logic sh_ir,
    output logic upd_ir
);

    tap_state_t state, next_state;

    always_ff @(posedge tck or posedge trst) begin
        if (trst)
            state <= TLR;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = TLR;
        case (state)
            TLR:     next_state = tms ? TLR    : RTI;
            RTI:     next_state = tms ? SEL_DR : RTI;
            SEL_DR:  next_state = tms ? SEL_IR : CAP_DR;
            CAP_DR:  next_state = tms ? EX1_DR : SH_DR;
            SH_DR:   next_state = tms ? EX1_DR : SH_DR;
            EX1_DR:  next_state = tms ? UPD_DR : PAU_DR;
            PAU_DR:  next_state = tms ? EX2_DR : PAU_DR;
            EX2_DR:  next_state = tms ? UPD_DR : SH_DR;
            UPD_DR:  next_state = tms ? SEL_DR : RTI;
            SEL_IR:  next_state = tms ? TLR    : CAP_IR;
            CAP_IR:  next_state = tms ? EX1_IR : SH_IR;
            SH_IR:   next_state = tms ? EX1_IR : SH_IR;
            EX1_IR:  next_state = tms ? UPD_IR : PAU_IR;
            PAU_IR:  next_state = tms ? EX2_IR : PAU_IR;
            EX2_IR:  next_state = tms ? UPD_IR : SH_IR;
            UPD_IR:  next_state = tms ? SEL_DR : RTI;
            default: next_state = TLR;
        endcase
    end

    assign next_tlr = (next_state == TLR);
    assign tlr      = (state == TLR);
    assign rti      = (state == RTI);
    assign cap_dr   = (state == CAP_DR);
    assign sh_dr    = (state == SH_DR);
    assign upd_dr   = (state == UPD_DR);
    assign cap_ir   = (state == CAP_IR);
    assign sh_ir    = (state == SH_IR);
    assign upd_ir   = (state == UPD_IR);

endmodule

// File: rtl/jtag_tap_core.sv
// JTAG TAP core: state machine, instruction register, BYPASS and IDCODE data
// registers, opcode decode and the TDO mux, plus N_USER external DR channels.
// Ports:
//   TCK, TRST, TMS, TDI   debug pins (TRST async active-high)
//   TDO, TDO_en           serial out and its enable (high in Shift-DR/IR)
//   ir_q                  current instruction
//   Reset, Run_idle, Capture_DR, Shift_DR, Update_DR,
//   Capture_IR, Shift_IR, Update_IR   state indications
//   user_sel              one-hot user channel select
//   user_tdo              serial outputs of the external user chains
module jtag_tap_core
    import jtag_pkg::*;
#(
    parameter int                    IR_WIDTH   = DEFAULT_IR_WIDTH,
    parameter logic [31:0]           IDCODE_VAL = DEFAULT_IDCODE_VAL,
    parameter logic [IR_WIDTH-1:0]   IDCODE_INS = IR_WIDTH'(DEFAULT_IDCODE_INS),
    parameter int                    N_USER     = DEFAULT_N_USER,
    parameter logic [IR_WIDTH-1:0]   USER_BASE  = IR_WIDTH'(DEFAULT_USER_BASE)
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                TDO,
    output logic                TDO_en,
    output logic [IR_WIDTH-1:0] ir_q,
    output logic                Reset,
    output logic                Run_idle,
    output logic                Capture_DR,
    output logic                Shift_DR,
    output logic                Update_DR,
    output logic                Capture_IR,
    output logic                Shift_IR,
    output logic                Update_IR,
    output logic [N_USER-1:0]   user_sel,
    input  logic [N_USER-1:0]   user_tdo
);

    logic                next_tlr;
    logic [IR_WIDTH-1:0] ir_sr;
    logic                bypass_r;
    logic [31:0]         idcode_sr;
    logic                user_bit;
    dr_sel_t             dr_sel;

    jtag_tap_fsm u_fsm (
        .tck      (TCK),
        .trst     (TRST),
        .tms      (TMS),
        .next_tlr (next_tlr),
        .tlr      (Reset),
        .rti      (Run_idle),
        .cap_dr   (Capture_DR),
        .sh_dr    (Shift_DR),
        .upd_dr   (Update_DR),
        .cap_ir   (Capture_IR),
        .sh_ir    (Shift_IR),
        .upd_ir   (Update_IR)
    );

    // Reloading on the edge that enters TLR makes IDCODE current in the
    // same cycle the Reset indication rises, not one cycle later.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST)
            ir_q <= IDCODE_INS;
        else if (next_tlr)
            ir_q <= IDCODE_INS;
        else if (Update_IR)
            ir_q <= ir_sr;
    end

    // Shift registers carry no reset: their contents only matter after a
    // capture, and TRST mid-shift leaves them as they were.
    always_ff @(posedge TCK) begin
        if (Capture_IR)
            ir_sr <= {{(IR_WIDTH-2){1'b0}}, 2'b01};
        else if (Shift_IR)
            ir_sr <= {TDI, ir_sr[IR_WIDTH-1:1]};
    end

    always_comb begin
        user_sel = '0;
        for (int i = 0; i < N_USER; i++)
            user_sel[i] = (ir_q == USER_BASE + IR_WIDTH'(i));
    end

    always_comb begin
        dr_sel = DR_BYPASS;
        if (ir_q == IDCODE_INS)
            dr_sel = DR_IDCODE;
        else if (|user_sel)
            dr_sel = DR_USER;
    end

    assign user_bit = |(user_sel & user_tdo);

    always_ff @(posedge TCK) begin
        if (dr_sel == DR_BYPASS) begin
            if (Capture_DR)
                bypass_r <= 1'b0;
            else if (Shift_DR)
                bypass_r <= TDI;
        end
    end

    always_ff @(posedge TCK) begin
        if (dr_sel == DR_IDCODE) begin
            if (Capture_DR)
                idcode_sr <= IDCODE_VAL;
            else if (Shift_DR)
                idcode_sr <= {TDI, idcode_sr[31:1]};
        end
    end

    always_comb begin
        TDO = 1'b0;
        if (Shift_IR) begin
            TDO = ir_sr[0];
        end else if (Shift_DR) begin
            case (dr_sel)
                DR_IDCODE: TDO = idcode_sr[0];
                DR_USER:   TDO = user_bit;
                default:   TDO = bypass_r;
            endcase
        end
    end

    assign TDO_en = Shift_DR | Shift_IR;

endmodule

// File: tb/tb_jtag_tap_core.sv
// Self-checking bench for jtag_tap_core: directed TAP scans followed by a
// random TMS/TDI/TRST phase, all compared against a name-based TAP model.
module tb_jtag_tap_core;

    logic       TCK = 1'b0;
    logic       TRST, TMS, TDI;
    logic       TDO, TDO_en;
    logic [4:0] ir_q;
    logic       Reset, Run_idle;
    logic       Capture_DR, Shift_DR, Update_DR;
    logic       Capture_IR, Shift_IR, Update_IR;
    logic [1:0] user_sel, user_tdo;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // Reference model: states are names, transitions come from two lookup
    // tables, registers are plain integers updated with arithmetic.
    string       m_state;
    string       nxt0[string];
    string       nxt1[string];
    int          m_ir_q;
    int          m_ir_sr;
    logic [31:0] m_idcode;
    logic        m_bypass;
    logic        last_tdo;

    jtag_tap_core dut (
        .TCK        (TCK),
        .TRST       (TRST),
        .TMS        (TMS),
        .TDI        (TDI),
        .TDO        (TDO),
        .TDO_en     (TDO_en),
        .ir_q       (ir_q),
        .Reset      (Reset),
        .Run_idle   (Run_idle),
        .Capture_DR (Capture_DR),
        .Shift_DR   (Shift_DR),
        .Update_DR  (Update_DR),
        .Capture_IR (Capture_IR),
        .Shift_IR   (Shift_IR),
        .Update_IR  (Update_IR),
        .user_sel   (user_sel),
        .user_tdo   (user_tdo)
    );

    always #5 TCK = ~TCK;

    // 0 = bypass, 1 = idcode, 2 = user channel
    function automatic int m_sel();
        if (m_ir_q == 1) return 1;
        if (m_ir_q >= 16 && m_ir_q < 18) return 2;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelStep(input logic tms, input logic tdi);
        if (m_state == "CAP_IR")
            m_ir_sr = 1;
        else if (m_state == "SH_IR")
            m_ir_sr = (m_ir_sr >> 1) | (int'(tdi) << 4);
        else if (m_state == "UPD_IR")
            m_ir_q = m_ir_sr;
        else if (m_state == "CAP_DR") begin
            if (m_sel() == 1) m_idcode = 32'h1000_0001;
            else if (m_sel() == 0) m_bypass = 1'b0;
        end else if (m_state == "SH_DR") begin
            if (m_sel() == 1) m_idcode = (m_idcode >> 1) | (32'(tdi) << 31);
            else if (m_sel() == 0) m_bypass = tdi;
        end
        m_state = tms ? nxt1[m_state] : nxt0[m_state];
        if (m_state == "TLR")
            m_ir_q = 1;
    endtask

    task automatic checkOutput();
        logic exp_tdo;
        int   sel;
        sel = m_sel();
        exp_tdo = 1'b0;
        if (m_state == "SH_IR")
            exp_tdo = m_ir_sr[0];
        else if (m_state == "SH_DR") begin
            if (sel == 1) exp_tdo = m_idcode[0];
            else if (sel == 2) exp_tdo = user_tdo[m_ir_q - 16];
            else exp_tdo = m_bypass;
        end
        chk("Reset",      32'(Reset),      32'(m_state == "TLR"));
        chk("Run_idle",   32'(Run_idle),   32'(m_state == "RTI"));
        chk("Capture_DR", 32'(Capture_DR), 32'(m_state == "CAP_DR"));
        chk("Shift_DR",   32'(Shift_DR),   32'(m_state == "SH_DR"));
        chk("Update_DR",  32'(Update_DR),  32'(m_state == "UPD_DR"));
        chk("Capture_IR", 32'(Capture_IR), 32'(m_state == "CAP_IR"));
        chk("Shift_IR",   32'(Shift_IR),   32'(m_state == "SH_IR"));
        chk("Update_IR",  32'(Update_IR),  32'(m_state == "UPD_IR"));
        chk("onehot_states",
            32'($countones({Reset, Run_idle, Capture_DR, Shift_DR, Update_DR,
                            Capture_IR, Shift_IR, Update_IR}) <= 1), 32'd1);
        chk("TDO_en",   32'(TDO_en), 32'(m_state == "SH_DR" || m_state == "SH_IR"));
        chk("TDO",      32'(TDO),    32'(exp_tdo));
        chk("ir_q",     32'(ir_q),   32'(m_ir_q));
        chk("user_sel", 32'(user_sel), (sel == 2) ? (32'd1 << (m_ir_q - 16)) : 32'd0);
        last_tdo = TDO;
    endtask

    // One TCK cycle: drive pins, clock, then sample at the falling edge.
    task automatic applyStimulus(input logic tms, input logic tdi);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        modelStep(tms, tdi);
        @(negedge TCK);
        user_tdo = 2'($urandom);
        #1;
        checkOutput();
    endtask

    // Asynchronous TRST pulse between clock edges.
    task automatic applyReset();
        TRST = 1'b1;
        #1;
        m_state = "TLR";
        m_ir_q  = 1;
        checkOutput();
        #1;
        TRST = 1'b0;
    endtask

    initial begin
        logic [31:0] word;
        logic [3:0]  b4;
        logic [4:0]  t5;
        int          walk[21];

        nxt0["TLR"] = "RTI";       nxt1["TLR"] = "TLR";
        nxt0["RTI"] = "RTI";       nxt1["RTI"] = "SEL_DR";
        nxt0["SEL_DR"] = "CAP_DR"; nxt1["SEL_DR"] = "SEL_IR";
        nxt0["CAP_DR"] = "SH_DR";  nxt1["CAP_DR"] = "EX1_DR";
        nxt0["SH_DR"] = "SH_DR";   nxt1["SH_DR"] = "EX1_DR";
        nxt0["EX1_DR"] = "PAU_DR"; nxt1["EX1_DR"] = "UPD_DR";
        nxt0["PAU_DR"] = "PAU_DR"; nxt1["PAU_DR"] = "EX2_DR";
        nxt0["EX2_DR"] = "SH_DR";  nxt1["EX2_DR"] = "UPD_DR";
        nxt0["UPD_DR"] = "RTI";    nxt1["UPD_DR"] = "SEL_DR";
        nxt0["SEL_IR"] = "CAP_IR"; nxt1["SEL_IR"] = "TLR";
        nxt0["CAP_IR"] = "SH_IR";  nxt1["CAP_IR"] = "EX1_IR";
        nxt0["SH_IR"] = "SH_IR";   nxt1["SH_IR"] = "EX1_IR";
        nxt0["EX1_IR"] = "PAU_IR"; nxt1["EX1_IR"] = "UPD_IR";
        nxt0["PAU_IR"] = "PAU_IR"; nxt1["PAU_IR"] = "EX2_IR";
        nxt0["EX2_IR"] = "SH_IR";  nxt1["EX2_IR"] = "UPD_IR";
        nxt0["UPD_IR"] = "RTI";    nxt1["UPD_IR"] = "SEL_DR";

        m_state  = "TLR";
        m_ir_q   = 1;
        m_ir_sr  = 0;
        m_idcode = '0;
        m_bypass = 1'b0;
        TRST = 1'b1;
        TMS = 1'b1;
        TDI = 1'b0;
        user_tdo = 2'b00;
        #2;
        checkOutput();
        @(negedge TCK);
        TRST = 1'b0;

        $display("[TB] step 1: TMS high x5 then Run-Test/Idle");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
        chk("tlr_ir_q", 32'(ir_q), 32'h01);
        applyStimulus(1'b0, 1'b0);

        $display("[TB] step 2: IDCODE scan");
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        word = '0;
        word[0] = last_tdo;
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b0, 1'($urandom));
            word[i] = last_tdo;
        end
        chk("idcode_stream", word, 32'h1000_0001);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);

        $display("[TB] step 3: load all-ones, bypass scan");
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        chk("ir_all_ones", 32'(ir_q), 32'h1f);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        b4[0] = last_tdo;
        applyStimulus(1'b0, 1'b1); b4[1] = last_tdo;
        applyStimulus(1'b0, 1'b0); b4[2] = last_tdo;
        applyStimulus(1'b0, 1'b1); b4[3] = last_tdo;
        applyStimulus(1'b1, 1'b1);
        chk("bypass_stream", 32'(b4), 32'h0a);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);

        $display("[TB] step 4: IR capture pattern, select user channel 1");
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        t5[0] = last_tdo;
        applyStimulus(1'b0, 1'b1); t5[1] = last_tdo;
        applyStimulus(1'b0, 1'b0); t5[2] = last_tdo;
        applyStimulus(1'b0, 1'b0); t5[3] = last_tdo;
        applyStimulus(1'b0, 1'b0); t5[4] = last_tdo;
        applyStimulus(1'b1, 1'b1);
        chk("ir_capture_stream", 32'(t5), 32'h01);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        chk("user_sel_ch1", 32'(user_sel), 32'h2);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'($urandom));
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);

        $display("[TB] step 5: walk all states, pause during IDCODE shift");
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b0);
        walk = '{0,1,0,0,1,0,0,1,0,1,1,1,1,0,1,0,1,1,1,1,1};
        foreach (walk[i]) applyStimulus(1'(walk[i]), 1'($urandom));
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'($urandom));
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'($urandom));

        $display("[TB] step 6: TRST during Shift-DR");
        applyReset();
        chk("trst_reset", 32'(Reset), 32'd1);

        $display("[TB] random phase");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0)
                applyReset();
            else
                applyStimulus(1'($urandom_range(0, 2) == 0), 1'($urandom));
        end

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
